dma_arb_mux: RTL
================

# dma_arb_mux

Parametrised, registered-grant arbiter and data multiplexer that gives one of NCH requesting DMA channels ownership of a shared DW-bit output path. Ownership lasts for a whole burst. The block adds three things to the fixed five-way grant mux used in the channel datapath:
- selectable round-robin or fixed-priority arbitration;
- a valid/ready handshake on the output;
- an idle-owner timeout that releases a stalled grant.

It sits between the per-channel DMA engines and the shared Wishbone master data path.

## Interface
Parameters:
- NCH, 5, number of channels (2..16)
- DW, 32, data width per channel
- RR, 1, 1 = round-robin, 0 = fixed priority (highest index wins)
- TMO, 16, idle-owner timeout in cycles; 0 disables the timeout

Ports:
- wb_clk_i  in  1  sole clock; all logic is on the rising edge
- wb_rst_i  in  1  synchronous, active-high reset
- req_i  in  NCH  per-channel request; doubles as data-valid while the channel owns the path
- last_i  in  NCH  per-channel end-of-burst flag, sampled on a transfer
- dat_i  in  NCH*DW  channel data; channel k occupies bits [k*DW +: DW]
- gnt_o  out  NCH  registered one-hot grant
- ack_o  out  NCH  one-hot transfer acknowledge: ack_o[k] = gnt_o[k] & valid_o & ready_i
- dat_o  out  DW  data of the owning channel
- valid_o  out  1  equals req_i[owner] while in GRANT
- ready_i  in  1  downstream ready

## Operation
The state machine has two states, IDLE and GRANT.

IDLE:
- If any req_i bit is set, latch the winner into the owner register, set gnt_o to one-hot(owner), clear the timeout counter, and go to GRANT.
- If no req_i bit is set, stay in IDLE.

Winner selection:
- RR=0: the highest set index wins.
- RR=1: search upward from rr_ptr with wrap-around; the first set bit wins. On grant, rr_ptr <= (winner+1) mod NCH.

GRANT:
- dat_o = dat_i[owner], valid_o = req_i[owner].
- A transfer occurs when valid_o & ready_i.
- A transfer with last_i[owner]=1 moves to IDLE and clears gnt_o.
- Timeout: while req_i[owner]=0, the counter increments; any cycle with req_i[owner]=1 clears it. When the counter reaches TMO (TMO>0), go to IDLE and clear gnt_o. No transfer occurs on that cycle.
- Requests from non-owners are ignored until the block returns to IDLE.

Outputs in IDLE: gnt_o=0, valid_o=0, ack_o=0, dat_o=0.

Boundary cases:
- last_i together with a stalled ready_i: no transfer, so the grant is held.
- The timeout counter saturates at TMO and never wraps.
- NCH not a power of two: the rr_ptr wrap uses mod NCH, so an index ≥ NCH is never selected.
- Reset during GRANT: next cycle is IDLE, all outputs 0, rr_ptr=0, counter=0. The burst is abandoned without an ack.

## Timing
Reset values:
- State IDLE, gnt_o=0, ack_o=0, valid_o=0, dat_o=0.
- rr_ptr=0, owner=0, timeout counter=0.

Latencies:
- Grant: a request seen in IDLE at edge t gives gnt_o, dat_o and valid_o at t+1 (one cycle).
- Data path: dat_o and valid_o are combinational from dat_i and req_i through the registered owner, with zero added latency.
- ack_o is combinational in the same cycle as the transfer.
- Release: a last transfer at cycle t gives gnt_o=0 at t+1. The earliest new grant is t+2, a mandatory one-cycle bubble.
- Timeout: the owner idle for TMO consecutive cycles starting at cycle s gives gnt_o=0 at s+TMO.

## Structure
- Package dma_arb_pkg holds:
  - the state enum (ST_IDLE, ST_GRANT);
  - the localparams IW=$clog2(NCH) and TW=$clog2(TMO+1) (minimum 1).
- One sub-module, arb_rr_pick: combinational rotate-priority picker with inputs req[NCH], ptr[IW], mode; outputs idx[IW] and any. It covers both RR and fixed-priority modes.
- The top level holds the FSM, the owner/rr_ptr/counter registers and the output mux.

## Test plan
- Reset: hold wb_rst_i for 3 cycles with req_i=5'b11111 → gnt_o=0, valid_o=0, dat_o=0 throughout. First grant one cycle after release: gnt_o=5'b00001 for RR=1, 5'b10000 for RR=0.
- Fixed priority (RR=0): req_i=5'b00110, each channel sends 1-beat bursts with last=1, ready_i=1 → grants ch2, then ch2 again while it keeps requesting. Ch1 is granted only after ch2 drops req.
- Round-robin (RR=1): all 5 channels request permanently with 1-beat bursts → grant order 0,1,2,3,4,0. Each grant is separated by one IDLE bubble.
- Burst hold: ch3 owns, 4-beat burst, ready_i toggling 1,0,1,0… → exactly 4 ack_o[3] pulses and dat_o matches the ch3 beats in order. ch0 requesting throughout is never acked; gnt_o changes only after the 4th beat.
- Timeout (TMO=4): ch1 granted, then req_i[1]=0 → gnt_o[1] stays 1 for 4 cycles and is cleared at s+4. ch2, requesting, is granted one cycle later.
- Mid-burst reset: ch4 owns after 2 of 4 beats, assert wb_rst_i one cycle → next cycle all outputs 0. Arbitration restarts from rr_ptr=0.

Source files
------------

// File: rtl/dma_arb_mux_pkg.sv
// Shared types and width helpers for the DMA channel arbiter/mux.
//   state_t  : arbiter FSM states (ST_IDLE, ST_GRANT)
//   idx_w()  : channel-index width for a given channel count
//   tmo_w()  : timeout-counter width for a given timeout (minimum 1 bit)
//   IW / TW  : widths for the default configuration (5 channels, timeout 16).
//              Parameterised modules re-derive them through the helpers.
package dma_arb_pkg;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  function automatic int idx_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  function automatic int tmo_w(input int tmo);
    return (tmo > 0) ? $clog2(tmo + 1) : 1;
  endfunction

  localparam int IW = idx_w(5);
  localparam int TW = tmo_w(16);

endpackage

// File: rtl/dma_arb_mux_if.sv
// Channel-side bundle of the DMA arbiter/mux.
//   req_i   : per-channel request / data-valid while owning
//   last_i  : per-channel end-of-burst flag
//   dat_i   : packed channel data, channel k at [k*DW +: DW]
//   ready_i : downstream ready
//   gnt_o   : registered one-hot grant
//   ack_o   : one-hot transfer acknowledge
//   dat_o   : data of the owning channel
//   valid_o : request of the owning channel while granted
// slave is the arbiter's view, master is the view of whoever drives
// the channels and the downstream ready.
interface dma_arb_mux_if #(
  parameter int NCH = 5,
  parameter int DW  = 32
);
  logic [NCH-1:0]    req_i;
  logic [NCH-1:0]    last_i;
  logic [NCH*DW-1:0] dat_i;
  logic              ready_i;
  logic [NCH-1:0]    gnt_o;
  logic [NCH-1:0]    ack_o;
  logic [DW-1:0]     dat_o;
  logic              valid_o;

  modport master (output req_i, last_i, dat_i, ready_i,
                  input  gnt_o, ack_o, dat_o, valid_o);
  modport slave  (input  req_i, last_i, dat_i, ready_i,
                  output gnt_o, ack_o, dat_o, valid_o);
endinterface

// File: rtl/dma_arb_mux_rr_pick.sv
// Combinational rotate-priority picker.
//   req  : request vector
//   ptr  : round-robin start index (always < NCH)
//   mode : 1 = search upward from ptr with wrap, 0 = highest index wins
//   idx  : winning channel index (0 when nothing requests)
//   any  : at least one request is set
module arb_rr_pick
  import dma_arb_pkg::*;
#(
  parameter int NCH = 5,
  parameter int IW  = idx_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  input  logic           mode,
  output logic [IW-1:0]  idx,
  output logic           any
);

  logic [2*NCH-1:0] rot;
  logic [IW:0]      sum;

  always_comb begin
    idx = '0;
    sum = '0;
    any = |req;
    // Doubling the vector makes the wrap-around a plain shift; bit off of
    // rot is channel (ptr+off) mod NCH. Descending scan leaves the smallest
    // offset, i.e. the first requester at or after ptr.
    rot = {req, req} >> ptr;
    if (mode) begin
      for (int off = NCH - 1; off >= 0; off--) begin
        if (rot[off]) begin
          sum = {1'b0, ptr} + (IW+1)'(off);
          if (sum >= (IW+1)'(NCH)) sum = sum - (IW+1)'(NCH);
          idx = sum[IW-1:0];
        end
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (req[i]) idx = IW'(i);
      end
    end
  end

endmodule

// File: rtl/dma_arb_mux.sv
// Registered-grant arbiter and data mux handing one of NCH DMA channels
// the shared DW-bit output path for a whole burst.
//   wb_clk_i : clock (rising edge)
//   wb_rst_i : synchronous active-high reset
//   bus      : dma_arb_mux_if slave (requests, data, grant, ack, handshake)
// Parameters: NCH channels, DW data width, RR (1 round-robin / 0 fixed
// priority), TMO idle-owner timeout in cycles (0 disables it).
module dma_arb_mux
  import dma_arb_pkg::*;
#(
  parameter int NCH = 5,
  parameter int DW  = 32,
  parameter int RR  = 1,
  parameter int TMO = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  dma_arb_mux_if.slave  bus
);

  localparam int             IW       = idx_w(NCH);
  localparam int             TW       = tmo_w(TMO);
  localparam logic [TW-1:0]  TMO_C    = TW'(TMO);
  localparam logic [IW-1:0]  LAST_IDX = IW'(NCH - 1);

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   rr_ptr;
  logic [NCH-1:0]  gnt;
  logic [TW-1:0]   tmo_cnt;

  logic [IW-1:0]   win_idx;
  logic            win_any;
  logic            own_req;
  logic            own_last;
  logic [DW-1:0]   dat_sel;
  logic            in_grant;
  logic            xfer;
  logic [TW-1:0]   tmo_nxt;
  logic            tmo_hit;

  arb_rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
    .req  (bus.req_i),
    .ptr  (rr_ptr),
    .mode (RR != 0),
    .idx  (win_idx),
    .any  (win_any)
  );

  // Owner-selected request, last flag and data.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    dat_sel  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (owner == IW'(k)) begin
        own_req  = bus.req_i[k];
        own_last = bus.last_i[k];
        dat_sel  = bus.dat_i[k*DW +: DW];
      end
    end
  end

  assign in_grant    = (state == ST_GRANT);
  assign bus.valid_o = in_grant & own_req;
  assign bus.dat_o   = in_grant ? dat_sel : '0;
  assign xfer        = bus.valid_o & bus.ready_i;
  // gnt is zero outside GRANT, so ack needs no extra state qualification.
  assign bus.ack_o   = gnt & {NCH{xfer}};
  assign bus.gnt_o   = gnt;

  // Saturating increment; release fires on the cycle the count would reach TMO,
  // so the grant drops exactly TMO cycles after the owner went quiet.
  assign tmo_nxt = (tmo_cnt == TMO_C) ? tmo_cnt : tmo_cnt + 1'b1;
  assign tmo_hit = (TMO != 0) && !own_req && (tmo_nxt == TMO_C);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state   <= ST_IDLE;
      gnt     <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      tmo_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_any) begin
            owner   <= win_idx;
            gnt     <= NCH'(1) << win_idx;
            rr_ptr  <= (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
            tmo_cnt <= '0;
            state   <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (xfer && own_last) begin
            gnt   <= '0;
            state <= ST_IDLE;
          end else if (tmo_hit) begin
            gnt   <= '0;
            state <= ST_IDLE;
          end else begin
            tmo_cnt <= own_req ? '0 : tmo_nxt;
          end
        end
      endcase
    end
  end

endmodule
